// File: rtl/aes_round_seq.sv
// aes_round_seq: AES round/key-index sequencer for 128/192/256-bit keys with stall, abort and error reporting
module aes_round_seq #(
    parameter int CNT_W = 5,
    parameter int NR128 = 10,
    parameter int NR192 = 12,
    parameter int NR256 = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic             enc,
    input  logic             stall,
    input  logic             abort,
    output logic [CNT_W-1:0] round,
    output logic [CNT_W-1:0] key_idx,
    output logic             round_first,
    output logic             round_last,
    output logic             busy,
    output logic             done,
    output logic             err
);
    typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] round_nx, key_idx_nx, nr;
    logic [1:0]       mode_q, mode_nx;
    logic             enc_q, enc_nx, err_nx, busy_nx;

    function automatic logic [CNT_W-1:0] nr_of(input logic [1:0] m);
        return m == 2'b11 ? CNT_W'(NR256) : m == 2'b10 ? CNT_W'(NR192) : CNT_W'(NR128);
    endfunction

    assign nr          = nr_of(mode_q);
    assign round_first = state == INIT;
    assign round_last  = state == RUN && round == nr;
    assign busy        = state == INIT || state == RUN;
    assign done        = state == DONE;

    // Next-state, next-round and latched-configuration decode; abort overrides everything
    always_comb begin
        state_nx = state;
        round_nx = round;
        mode_nx  = mode_q;
        enc_nx   = enc_q;
        err_nx   = 1'b0;
        if (abort) begin
            state_nx = IDLE;
            round_nx = '0;
        end else begin
            err_nx = start && state != IDLE;
            case (state)
                IDLE: if (start) begin
                    state_nx = INIT;
                    round_nx = '0;
                    mode_nx  = mode;
                    enc_nx   = enc;
                end
                INIT: if (!stall) begin
                    state_nx = RUN;
                    round_nx = CNT_W'(1);
                end
                RUN: if (!stall) begin
                    state_nx = round == nr ? DONE : RUN;
                    round_nx = round == nr ? '0 : round + CNT_W'(1);
                end
                default: state_nx = IDLE;
            endcase
        end
        busy_nx    = state_nx == INIT || state_nx == RUN;
        key_idx_nx = !busy_nx ? '0 : enc_nx ? round_nx : nr_of(mode_nx) - round_nx;
    end

    // State, counters and latched configuration registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            round   <= '0;
            key_idx <= '0;
            mode_q  <= 2'b00;
            enc_q   <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_nx;
            round   <= round_nx;
            key_idx <= key_idx_nx;
            mode_q  <= mode_nx;
            enc_q   <= enc_nx;
            err     <= err_nx;
        end
    end
endmodule
